// File: rtl/reg_bank_sb.sv
// Sixteen-entry register bank with a pending-write scoreboard and issue-stall detection.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data and clears hazards early.
module reg_bank_sb #(
   parameter int L      = 16,
   parameter int sel_L  = 4,
   parameter int word_L = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [sel_L-1:0]              wr_addr,
   input  logic [word_L-1:0]             wr_data,
   input  logic                          iss_en,
   input  logic [sel_L-1:0]              iss_dst,
   input  logic [sel_L-1:0]              src_a,
   input  logic [sel_L-1:0]              src_b,
   input  logic                          src_a_vld,
   input  logic                          src_b_vld,
   output logic [0:L-1][word_L-1:0]      regs_out,
   output logic [L-1:0]                  pend,
   output logic                          stall,
   output logic                          wr_err
);

   logic [0:L-1][word_L-1:0] regs_q, regs_d;
   logic [L-1:0]             pend_q, pend_d;
   logic                     wr_err_q, wr_err_d;
   logic [L-1:0]             wr_hit;
   logic [L-1:0]             hz;
   logic                     iss_acc;

   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_entry
         assign wr_hit[gi] = wr_en & (wr_addr == sel_L'(gi));
`ifdef WB_BYPASS_EN
         // A writeback landing this cycle already resolves the hazard on its register.
         assign hz[gi]       = pend_q[gi] & ~wr_hit[gi];
         assign regs_out[gi] = wr_hit[gi] ? wr_data : regs_q[gi];
`else
         assign hz[gi]       = pend_q[gi];
         assign regs_out[gi] = regs_q[gi];
`endif
         // Issue set takes priority over a same-cycle writeback clear.
         assign pend_d[gi] = (iss_acc & (iss_dst == sel_L'(gi))) | (pend_q[gi] & ~wr_hit[gi]);
      end
   endgenerate

   assign stall   = iss_en & ((src_a_vld & hz[src_a]) | (src_b_vld & hz[src_b]) | hz[iss_dst]);
   assign iss_acc = iss_en & ~stall;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   assign wr_err_d = wr_err_q | (wr_en & ~pend_q[wr_addr]);

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q   <= '0;
         pend_q   <= '0;
         wr_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         pend_q   <= pend_d;
         wr_err_q <= wr_err_d;
      end
   end

   assign pend   = pend_q;
   assign wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_bank_sb;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int K_STALL = 0;
   localparam int K_PEND  = 1;
   localparam int K_ERR   = 2;
   localparam int K_REG   = 3;

   logic              clk = 1'b0;
   logic              rst, wr_en, iss_en, src_a_vld, src_b_vld;
   logic [3:0]        wr_addr, iss_dst, src_a, src_b;
   logic [15:0]       wr_data;
   logic [0:15][15:0] regs_out;
   logic [15:0]       pend;
   logic              stall, wr_err;

   reg_bank_sb #(.L(16), .sel_L(4), .word_L(16)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_dst(iss_dst), .src_a(src_a), .src_b(src_b),
      .src_a_vld(src_a_vld), .src_b_vld(src_b_vld),
      .regs_out(regs_out), .pend(pend), .stall(stall), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       name;
      int          kind;
      int          idx;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] observe(int kind, int idx);
      case (kind)
         K_STALL: return {31'd0, stall};
         K_PEND:  return {16'd0, pend};
         K_ERR:   return {31'd0, wr_err};
         default: return {16'd0, regs_out[idx]};
      endcase
   endfunction

   // Monitor: compares every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t        e;
         logic [31:0] act;
         e   = sb.pop_front();
         act = observe(e.kind, e.idx);
         n_vec++;
         if (e.cyc != cyc || act !== e.exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, act, e.exp);
         end else begin
            $display("ok   %s cyc=%0d val=%h", e.name, cyc, act);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; wr_en = 0; iss_en = 0; src_a_vld = 0; src_b_vld = 0;
      wr_addr = 0; wr_data = 0; iss_dst = 0; src_a = 0; src_b = 0;
   endtask

   task automatic chk(string n, int k, int i, logic [31:0] v);
      sb.push_back('{cyc, n, k, i, v});
   endtask

   task automatic wr(logic [3:0] a, logic [15:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
   endtask

   task automatic issue(logic [3:0] dst);
      iss_en = 1; iss_dst = dst;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1;
      step(); step();
      idle();
      chk("reset_pend", K_PEND, 0, 32'h0);
      chk("reset_err", K_ERR, 0, 32'h0);
      chk("reset_r3", K_REG, 3, 32'h0);
      chk("reset_stall", K_STALL, 0, 32'h0);

      // Reset: write r3, then reset while a write and an issue are presented.
      wr(4'd3, 16'h1234);
      step(); idle();
      chk("pre_rst_r3", K_REG, 3, 32'h1234);
      chk("pre_rst_err", K_ERR, 0, 32'h1);
      rst = 1; wr(4'd3, 16'h5555); issue(4'd4);
      step(); idle();
      chk("rst_r3", K_REG, 3, 32'h0);
      chk("rst_pend", K_PEND, 0, 32'h0);
      chk("rst_err", K_ERR, 0, 32'h0);

      // RAW on r5: producer issues in cycle 1, consumer (dst r6, src_a r5) from cycle 2.
      issue(4'd5);
      chk("raw_c1_stall", K_STALL, 0, 32'h0);
      step(); idle();
      issue(4'd6); src_a = 4'd5; src_a_vld = 1;
      chk("raw_c2_pend", K_PEND, 0, 32'h0020);
      chk("raw_c2_stall", K_STALL, 0, 32'h1);
      step();
      chk("raw_c3_stall", K_STALL, 0, 32'h1);
      step();
      wr(4'd5, 16'hBEEF);
      chk("raw_c4_stall", K_STALL, 0, BYP ? 32'h0 : 32'h1);
      chk("raw_c4_r5", K_REG, 5, BYP ? 32'hBEEF : 32'h0);
      step();
      wr_en = 0;
      if (BYP) begin
         iss_en = 0; src_a_vld = 0;
      end
      chk("raw_c5_r5", K_REG, 5, 32'hBEEF);
      chk("raw_c5_pend", K_PEND, 0, BYP ? 32'h0040 : 32'h0);
      chk("raw_c5_stall", K_STALL, 0, 32'h0);
      step(); idle();
      chk("raw_c6_pend", K_PEND, 0, 32'h0040);
      chk("raw_c6_err", K_ERR, 0, 32'h0);
      wr(4'd6, 16'h0666);
      step(); idle();
      chk("raw_done_pend", K_PEND, 0, 32'h0);

      // WAW on r7.
      issue(4'd7);
      step();
      chk("waw_b_stall", K_STALL, 0, 32'h1);
      chk("waw_b_pend", K_PEND, 0, 32'h0080);
      step();
      chk("waw_c_pend", K_PEND, 0, 32'h0080);
      wr(4'd7, 16'h0777);
      chk("waw_c_stall", K_STALL, 0, BYP ? 32'h0 : 32'h1);
      step();
      wr_en = 0;
      if (BYP) iss_en = 0;
      chk("waw_d_pend", K_PEND, 0, BYP ? 32'h0080 : 32'h0);
      chk("waw_d_stall", K_STALL, 0, 32'h0);
      step(); idle();
      chk("waw_e_pend", K_PEND, 0, 32'h0080);
      chk("waw_e_err", K_ERR, 0, 32'h0);
      wr(4'd7, 16'h0007);
      step(); idle();

      // Simultaneous accepted issue and writeback to r2 (r2 not pending beforehand).
      issue(4'd2); wr(4'd2, 16'h00AA);
      chk("sim_stall", K_STALL, 0, 32'h0);
      step(); idle();
      chk("sim_pend", K_PEND, 0, 32'h0004);
      chk("sim_r2", K_REG, 2, 32'h00AA);
      chk("sim_err", K_ERR, 0, 32'h1);
      wr(4'd2, 16'h0002);
      step(); idle();
      chk("sim_clr_pend", K_PEND, 0, 32'h0);
      chk("sim_err_sticky", K_ERR, 0, 32'h1);
      rst = 1;
      step(); idle();
      chk("sim_rst_err", K_ERR, 0, 32'h0);
      chk("sim_rst_r2", K_REG, 2, 32'h0);

      // Error flag: stray write to r9, then legal traffic on r1.
      wr(4'd9, 16'h0009);
      step(); idle();
      chk("err_set", K_ERR, 0, 32'h1);
      chk("err_r9", K_REG, 9, 32'h0009);
      issue(4'd1);
      step(); idle();
      wr(4'd1, 16'h0101);
      step(); idle();
      chk("err_hold", K_ERR, 0, 32'h1);
      chk("err_r1", K_REG, 1, 32'h0101);
      chk("err_pend", K_PEND, 0, 32'h0);
      rst = 1;
      step(); idle();
      chk("err_rst", K_ERR, 0, 32'h0);
      chk("err_rst_r9", K_REG, 9, 32'h0);

      // Throughput: sixteen back-to-back issues with no sources.
      for (int i = 0; i < 16; i++) begin
         issue(4'(i));
         chk($sformatf("tput_stall_%0d", i), K_STALL, 0, 32'h0);
         step();
      end
      idle();
      chk("tput_pend", K_PEND, 0, 32'hFFFF);
      issue(4'd15);
      chk("full_waw_stall", K_STALL, 0, 32'h1);
      step(); idle();
      chk("full_pend_hold", K_PEND, 0, 32'hFFFF);

      step(); step();
      if (sb.size() != 0) begin
         n_err += sb.size();
         $display("FAIL unchecked got=%0d want=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
